fess_sensor_qualifier: RTL and testbench

Upstream conditioning stage for the FESS controller. Takes six raw threshold-comparator bits from the sensor front-end boards, which are asynchronous and noisy. Each bit is synchronised, sampled on a programmable tick, and passed through a per-channel persistence/hysteresis filter, with optional latching for safety-critical channels. The six qualified flags drive the S1..S6 inputs of the FESS control/FSM block directly.

---
 rtl/fess_pkg.sv | 27 ++
 rtl/fess_chan_filter.sv | 61 ++++++
 rtl/fess_sensor_qualifier.sv | 89 ++++++++
 tb/tb_fess_sensor_qualifier.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fess_pkg.sv
// Shared constants for the FESS sensor path: channel map, default qualification
// timing and the controller state encodings.
package fess_pkg;

  localparam int NUM_SENSORS = 6;

  localparam int IDX_S1_ROTARY   = 0;
  localparam int IDX_S2_ACCEL    = 1;
  localparam int IDX_S3_THERMAL  = 2;
  localparam int IDX_S4_VACUUM   = 3;
  localparam int IDX_S5_STRAIN   = 4;
  localparam int IDX_S6_ACOUSTIC = 5;

  localparam int DEF_SAMPLE_DIV = 1;
  localparam int DEF_ASSERT_CNT = 4;
  localparam int DEF_CLEAR_CNT  = 8;
  localparam logic [NUM_SENSORS-1:0] DEF_LATCH_MASK = 6'b001000;

  localparam logic [1:0] ST_NORMAL  = 2'b00;
  localparam logic [1:0] ST_WARNING = 2'b01;
  localparam logic [1:0] ST_CRISIS  = 2'b10;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fess_chan_filter.sv
// One sensor channel: persistence counter with asymmetric set/clear thresholds
// and an optional sticky (latched) flag.
module fess_chan_filter
  import fess_pkg::*;
#(
  parameter int ASSERT_CNT = DEF_ASSERT_CNT,
  parameter int CLEAR_CNT  = DEF_CLEAR_CNT,
  parameter bit LATCH_EN   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sampleTick,
  input  logic syncIn,
  input  logic latchClr,
  output logic flag,
  output logic toggle
);

  localparam int CW = $clog2(maxInt(ASSERT_CNT, CLEAR_CNT) + 1);
  localparam logic [CW-1:0] ASSERT_TH = CW'(ASSERT_CNT);
  localparam logic [CW-1:0] CLEAR_TH  = CW'(CLEAR_CNT);

  logic [CW-1:0] cnt, cntNext, cntInc, threshold;
  logic          flagNext;

  always_comb begin
    // NOTE: every variable gets a default first, so no branch can leave it unassigned and infer a latch.
    cntNext   = cnt;
    flagNext  = flag;
    cntInc    = cnt + 1'b1;
    threshold = flag ? CLEAR_TH : ASSERT_TH;
    if (LATCH_EN && latchClr) begin
      // The clear takes priority over a coincident tick, which is then not counted.
      cntNext  = '0;
      flagNext = 1'b0;
    end else if (sampleTick) begin
      if ((LATCH_EN && flag) || (syncIn == flag)) begin
        cntNext = '0;
      end else if (cntInc == threshold) begin
        cntNext  = '0;
        flagNext = ~flag;
      end else begin
        cntNext = cntInc;
      end
    end
  end

  assign toggle = flagNext ^ flag;

  // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else begin
      cnt  <= cntNext;
      flag <= flagNext;
    end
  end

endmodule

// File: rtl/fess_sensor_qualifier.sv
// Qualifies six asynchronous comparator bits into clean S1..S6 flags for the
// FESS controller: synchroniser, sample prescaler, per-channel filters.
module fess_sensor_qualifier
  import fess_pkg::*;
#(
  parameter int NUM_SENSORS = fess_pkg::NUM_SENSORS,
  parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int ASSERT_CNT  = DEF_ASSERT_CNT,
  parameter int CLEAR_CNT   = DEF_CLEAR_CNT,
  parameter logic [NUM_SENSORS-1:0] LATCH_MASK = DEF_LATCH_MASK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SENSORS-1:0] raw_in,
  input  logic                   latch_clr,
  output logic [NUM_SENSORS-1:0] sensor_q,
  output logic                   change_pulse,
  output logic                   settled
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);
  localparam int SETTLE_MAX = maxInt(ASSERT_CNT, CLEAR_CNT);
  localparam int SW = $clog2(SETTLE_MAX + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_MAX - 1);

  logic [NUM_SENSORS-1:0] syncMeta, syncOut, toggleVec;
  logic [PW-1:0]          preCnt;
  logic [SW-1:0]          settleCnt;
  logic                   sampleTick;

  // Raw bits only ever reach the filters through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta <= '0;
      syncOut  <= '0;
    end else begin
      syncMeta <= raw_in;
      syncOut  <= syncMeta;
    end
  end

  assign sampleTick = (preCnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preCnt <= '0;
    end else begin
      preCnt <= sampleTick ? '0 : preCnt + 1'b1;
    end
  end

  // Advisory only: enough ticks have passed for any filter to have resolved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settleCnt <= '0;
      settled   <= 1'b0;
    end else if (sampleTick && !settled) begin
      settleCnt <= settleCnt + 1'b1;
      if (settleCnt == SETTLE_LAST) settled <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
    fess_chan_filter #(
      .ASSERT_CNT (ASSERT_CNT),
      .CLEAR_CNT  (CLEAR_CNT),
      .LATCH_EN   (LATCH_MASK[i])
    ) u_filter (
      .clk        (clk),
      .rst_n      (rst_n),
      .sampleTick (sampleTick),
      .syncIn     (syncOut[i]),
      .latchClr   (latch_clr),
      .flag       (sensor_q[i]),
      .toggle     (toggleVec[i])
    );
  end

  // Registered from the filters' next-state so the pulse lines up with the sensor_q edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_pulse <= 1'b0;
    end else begin
      change_pulse <= |toggleVec;
    end
  end

endmodule

// File: tb/tb_fess_sensor_qualifier.sv
// Self-checking bench for fess_sensor_qualifier: directed scenarios plus a
// randomized run against a run-length reference model.
module tb_fess_sensor_qualifier;

  localparam bit [5:0] LMASK = 6'b001000;
  localparam int A_CNT = 4;
  localparam int C_CNT = 8;

  logic       clk, rst_n;
  logic [5:0] rawIn, sensorQ, rawDiv, sensorQDiv;
  logic       latchClr, latchClrDiv, changePulse, settled, changeDiv, settledDiv;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state: raw history, flags, run lengths of disagreeing samples.
  bit [5:0] mD1, mD2, mFlag;
  int       mRun[6];
  int       mTicks;
  bit       mChange, mSettled;

  fess_sensor_qualifier dut (
    .clk(clk), .rst_n(rst_n), .raw_in(rawIn), .latch_clr(latchClr),
    .sensor_q(sensorQ), .change_pulse(changePulse), .settled(settled)
  );

  fess_sensor_qualifier #(.SAMPLE_DIV(4)) dutDiv (
    .clk(clk), .rst_n(rst_n), .raw_in(rawDiv), .latch_clr(latchClrDiv),
    .sensor_q(sensorQDiv), .change_pulse(changeDiv), .settled(settledDiv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelEdge();
    bit [5:0] prev;
    if (!rst_n) begin
      mD1 = '0; mD2 = '0; mFlag = '0; mChange = 0; mSettled = 0; mTicks = 0;
      for (int i = 0; i < 6; i++) mRun[i] = 0;
      return;
    end
    prev = mFlag;
    for (int i = 0; i < 6; i++) begin
      if (LMASK[i] && latchClr) begin
        mFlag[i] = 0; mRun[i] = 0;
      end else if ((LMASK[i] && mFlag[i]) || (mD2[i] == mFlag[i])) begin
        mRun[i] = 0;
      end else begin
        mRun[i]++;
        if (mRun[i] == (mFlag[i] ? C_CNT : A_CNT)) begin
          mFlag[i] = ~mFlag[i]; mRun[i] = 0;
        end
      end
    end
    mChange = (mFlag != prev);
    if (mTicks < C_CNT) mTicks++;
    mSettled = (mTicks >= C_CNT);
    mD2 = mD1;
    mD1 = rawIn;
  endtask

  // Advance one clock edge; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_glitch();
    rawIn = 6'h02;
    repeat (3) step();
    rawIn = 6'h00;
    for (int k = 1; k <= 10; k++) begin
      step();
      testsRun++;
      if (sensorQ !== 6'h00) begin
        testsFailed++;
        $display("FAIL glitch_reject k=%0d: sensor_q=%h want 00", k, sensorQ);
      end
    end
    rawIn = 6'h02;
    for (int k = 1; k <= 7; k++) begin
      step();
      testsRun++;
      if (sensorQ !== ((k >= 6) ? 6'h02 : 6'h00) || changePulse !== (k == 6)) begin
        testsFailed++;
        $display("FAIL assert_latency edge=%0d: sensor_q=%h pulse=%b want %h/%b",
                 k, sensorQ, changePulse, (k >= 6) ? 6'h02 : 6'h00, k == 6);
      end
    end
  endtask

  task automatic test_hysteresis();
    rawIn = 6'h00;
    repeat (7) step();
    rawIn = 6'h02;
    for (int k = 1; k <= 15; k++) begin
      step();
      testsRun++;
      if (sensorQ !== 6'h02 || changePulse !== 1'b0) begin
        testsFailed++;
        $display("FAIL short_drop k=%0d: sensor_q=%h pulse=%b want 02/0", k, sensorQ, changePulse);
      end
    end
    rawIn = 6'h00;
    for (int k = 1; k <= 11; k++) begin
      step();
      testsRun++;
      if (sensorQ !== ((k >= 10) ? 6'h00 : 6'h02) || changePulse !== (k == 10)) begin
        testsFailed++;
        $display("FAIL clear_latency edge=%0d: sensor_q=%h pulse=%b want %h/%b",
                 k, sensorQ, changePulse, (k >= 10) ? 6'h00 : 6'h02, k == 10);
      end
    end
  endtask

  task automatic test_latch();
    rawIn = 6'h08;
    repeat (10) step();
    rawIn = 6'h00;
    for (int k = 1; k <= 50; k++) begin
      step();
      testsRun++;
      if (sensorQ !== 6'h08) begin
        testsFailed++;
        $display("FAIL latch_hold k=%0d: sensor_q=%h want 08", k, sensorQ);
      end
    end
    latchClr = 1'b1;
    step();
    latchClr = 1'b0;
    testsRun++;
    if (sensorQ !== 6'h00 || changePulse !== 1'b1) begin
      testsFailed++;
      $display("FAIL latch_clear: sensor_q=%h pulse=%b want 00/1", sensorQ, changePulse);
    end
    rawIn = 6'h0A;
    repeat (12) step();
    latchClr = 1'b1;
    step();
    latchClr = 1'b0;
    testsRun++;
    if (sensorQ !== 6'h02 || changePulse !== 1'b1) begin
      testsFailed++;
      $display("FAIL latch_clear_selective: sensor_q=%h pulse=%b want 02/1", sensorQ, changePulse);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      testsRun++;
      if (sensorQ !== ((k == 4) ? 6'h0A : 6'h02)) begin
        testsFailed++;
        $display("FAIL latch_reassert k=%0d: sensor_q=%h want %h", k, sensorQ, (k == 4) ? 6'h0A : 6'h02);
      end
    end
  endtask

  task automatic test_reset();
    rawIn = 6'h3F;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (sensorQ !== 6'h00 || changePulse !== 1'b0 || settled !== 1'b0) begin
      testsFailed++;
      $display("FAIL async_reset: sensor_q=%h pulse=%b settled=%b want 00/0/0",
               sensorQ, changePulse, settled);
    end
    step(); step();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      testsRun++;
      if (settled !== (k == 8) || sensorQ !== ((k >= 6) ? 6'h3F : 6'h00)) begin
        testsFailed++;
        $display("FAIL reset_release edge=%0d: settled=%b sensor_q=%h want %b/%h",
                 k, settled, sensorQ, k == 8, (k >= 6) ? 6'h3F : 6'h00);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    rawIn = 6'h01;
    step(); step();
    rst_n = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    testsRun++;
    if (sensorQ !== 6'h00) begin
      testsFailed++;
      $display("FAIL mid_reset: sensor_q=%h want 00", sensorQ);
    end
    step(); step();
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      testsRun++;
      if (sensorQ !== ((k == 6) ? 6'h01 : 6'h00)) begin
        testsFailed++;
        $display("FAIL mid_reset_restart edge=%0d: sensor_q=%h want %h", k, sensorQ, (k == 6) ? 6'h01 : 6'h00);
      end
    end
  endtask

  task automatic test_prescaled();
    int firstEdge;
    int pulses;
    logic [5:0] firstVal;
    rawIn = 6'h00;
    rawDiv = 6'h00;
    doReset();
    repeat ($urandom_range(0, 3)) step();
    rawDiv = 6'h3F;
    firstEdge = 0;
    firstVal = '0;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (changeDiv === 1'b1) pulses++;
      if (firstEdge == 0 && sensorQDiv !== 6'h00) begin
        firstEdge = k;
        firstVal = sensorQDiv;
      end
    end
    testsRun++;
    if (firstEdge < 15 || firstEdge > 18 || firstVal !== 6'h3F) begin
      testsFailed++;
      $display("FAIL prescaled_rise: edge=%0d value=%h want edge 15..18 value 3f", firstEdge, firstVal);
    end
    testsRun++;
    if (pulses != 1) begin
      testsFailed++;
      $display("FAIL prescaled_pulse: pulses=%0d want 1", pulses);
    end
  endtask

  task automatic test_random();
    rawIn = 6'h00;
    latchClr = 1'b0;
    doReset();
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 9) == 0) rawIn[b] = ~rawIn[b];
      latchClr = ($urandom_range(0, 29) == 0);
      step();
      testsRun++;
      if (sensorQ !== mFlag || changePulse !== mChange || settled !== mSettled) begin
        testsFailed++;
        $display("FAIL random cyc=%0d: q=%h pulse=%b settled=%b want %h/%b/%b",
                 k, sensorQ, changePulse, settled, mFlag, mChange, mSettled);
      end
    end
    latchClr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rawIn = 6'h00;
    rawDiv = 6'h00;
    latchClr = 1'b0;
    latchClrDiv = 1'b0;
    #1;
    testsRun++;
    if (sensorQ !== 6'h00 || changePulse !== 1'b0 || settled !== 1'b0) begin
      testsFailed++;
      $display("FAIL initial_reset: sensor_q=%h pulse=%b settled=%b want 00/0/0",
               sensorQ, changePulse, settled);
    end
    step(); step();
    rst_n = 1'b1;
    test_glitch();
    test_hysteresis();
    test_latch();
    test_reset();
    test_reset_mid();
    test_prescaled();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
